agu_nd_burst: RTL

N-dimensional address generation unit that turns a strided tensor-tile descriptor into a stream of aligned, boundary-safe memory burst requests. It supersedes the single-dimension AGU. It adds a parameterised dimension count, signed per-dimension strides, bus-width beats, and splitting at the burst-length limit and the address-boundary limit. It sits between the accelerator's DMA/tile scheduler (descriptor side) and the AXI read/write address channel (request side).

---
 rtl/agu_nd_burst.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/agu_nd_burst.sv
`default_nettype none
// ============================================================================
// Module      : agu_nd_burst
// Description : N-dimensional address generation unit. Accepts a strided
//               tensor-tile descriptor and emits aligned burst requests that
//               never exceed MAX_BURST_BEATS and never cross BOUNDARY_BYTES.
// Ports       : clk_i/rst_ni          clock, async active-low reset
//               cfg_*                 descriptor handshake (base/count/stride)
//               abort_i               flush current descriptor
//               req_*                 burst request channel (addr/len/size/last)
//               busy_o / done_o       status, one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module agu_nd_burst #(
    parameter int ADDR_WIDTH      = 32,
    parameter int NUM_DIMS        = 3,
    parameter int CNT_WIDTH       = 16,
    parameter int DATA_BYTES      = 8,
    parameter int MAX_BURST_BEATS = 16,
    parameter int BOUNDARY_BYTES  = 4096
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           cfg_valid_i,
    output logic                           cfg_ready_o,
    input  logic [ADDR_WIDTH-1:0]          cfg_base_i,
    input  logic [NUM_DIMS*CNT_WIDTH-1:0]  cfg_count_i,
    input  logic [NUM_DIMS*ADDR_WIDTH-1:0] cfg_stride_i,
    input  logic                           abort_i,
    output logic                           req_valid_o,
    input  logic                           req_ready_i,
    output logic [ADDR_WIDTH-1:0]          req_addr_o,
    output logic [7:0]                     req_len_o,
    output logic [2:0]                     req_size_o,
    output logic                           req_last_o,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int SIZE_LOG2 = $clog2(DATA_BYTES);
    localparam logic [2:0]            REQ_SIZE   = 3'(SIZE_LOG2);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] BND_MASK   = ADDR_WIDTH'(BOUNDARY_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] BND_BEATS  = ADDR_WIDTH'(BOUNDARY_BYTES / DATA_BYTES);
    localparam logic [ADDR_WIDTH-1:0] MAX_BEATS  = ADDR_WIDTH'(MAX_BURST_BEATS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;                 // start address of current burst
    logic [CNT_WIDTH-1:0]  row_left;             // dim-0 beats not yet issued
    logic [CNT_WIDTH-1:0]  count    [NUM_DIMS];
    logic [ADDR_WIDTH-1:0] stride   [NUM_DIMS];
    logic [CNT_WIDTH-1:0]  idx      [NUM_DIMS];
    logic [ADDR_WIDTH-1:0] dim_base [NUM_DIMS];

    logic [ADDR_WIDTH-1:0] row_beats;
    logic [ADDR_WIDTH-1:0] bnd_beats;
    logic [ADDR_WIDTH-1:0] beats;
    logic                  row_empty;
    logic                  all_end;
    logic                  burst_last;
    logic                  any_zero;
    logic                  found;
    logic [ADDR_WIDTH-1:0] carry_base;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic [CNT_WIDTH-1:0]  nxt_row;
    logic [CNT_WIDTH-1:0]  nxt_idx  [NUM_DIMS];
    logic [ADDR_WIDTH-1:0] nxt_base [NUM_DIMS];

    // Burst size: smallest of row remainder, burst limit, room to boundary.
    always_comb begin
        row_beats = ADDR_WIDTH'(row_left);
        bnd_beats = BND_BEATS - ((addr & BND_MASK) >> SIZE_LOG2);
        beats     = (row_beats < MAX_BEATS) ? row_beats : MAX_BEATS;
        if (bnd_beats < beats) begin
            beats = bnd_beats;
        end
        row_empty = (row_beats == beats);
    end

    always_comb begin
        all_end  = 1'b1;
        any_zero = 1'b0;
        for (int d = 1; d < NUM_DIMS; d++) begin
            if (idx[d] != count[d] - CNT_ONE) begin
                all_end = 1'b0;
            end
        end
        for (int d = 0; d < NUM_DIMS; d++) begin
            if (cfg_count_i[d*CNT_WIDTH +: CNT_WIDTH] == '0) begin
                any_zero = 1'b1;
            end
        end
        burst_last = row_empty && all_end;
    end

    // Cursor advance: inside a row step the address; on row exhaustion carry
    // into the lowest dimension that still has iterations left and rebase
    // every lower dimension onto its new base.
    always_comb begin
        nxt_addr   = addr + (beats << SIZE_LOG2);
        nxt_row    = row_left - CNT_WIDTH'(beats);
        nxt_idx    = idx;
        nxt_base   = dim_base;
        found      = 1'b0;
        carry_base = '0;
        if (row_empty) begin
            nxt_row = count[0];
            for (int d = 1; d < NUM_DIMS; d++) begin
                if (!found && (idx[d] != count[d] - CNT_ONE)) begin
                    found       = 1'b1;
                    carry_base  = dim_base[d] + stride[d];
                    nxt_idx[d]  = idx[d] + CNT_ONE;
                    nxt_base[d] = carry_base;
                    nxt_addr    = carry_base;
                    for (int e = 1; e < NUM_DIMS; e++) begin
                        if (e < d) begin
                            nxt_idx[e]  = '0;
                            nxt_base[e] = carry_base;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            addr     <= '0;
            row_left <= '0;
            for (int d = 0; d < NUM_DIMS; d++) begin
                count[d]    <= '0;
                stride[d]   <= '0;
                idx[d]      <= '0;
                dim_base[d] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_valid_i) begin
                        addr     <= cfg_base_i & ALIGN_MASK;
                        row_left <= cfg_count_i[CNT_WIDTH-1:0];
                        for (int d = 0; d < NUM_DIMS; d++) begin
                            count[d]    <= cfg_count_i[d*CNT_WIDTH +: CNT_WIDTH];
                            stride[d]   <= cfg_stride_i[d*ADDR_WIDTH +: ADDR_WIDTH] & ALIGN_MASK;
                            idx[d]      <= '0;
                            dim_base[d] <= cfg_base_i & ALIGN_MASK;
                        end
                        state <= any_zero ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (abort_i) begin
                        state <= ST_IDLE;
                    end else if (req_ready_i) begin
                        if (burst_last) begin
                            state <= ST_DONE;
                        end else begin
                            addr     <= nxt_addr;
                            row_left <= nxt_row;
                            idx      <= nxt_idx;
                            dim_base <= nxt_base;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Payload is driven straight from cursor registers, so it cannot move
    // while a request is stalled.
    assign cfg_ready_o = (state == ST_IDLE);
    assign busy_o      = (state != ST_IDLE);
    assign req_valid_o = (state == ST_ISSUE);
    assign req_addr_o  = addr;
    assign req_len_o   = (state == ST_ISSUE) ? 8'(beats - ADDR_ONE) : 8'd0;
    assign req_size_o  = (state == ST_ISSUE) ? REQ_SIZE : 3'd0;
    assign req_last_o  = (state == ST_ISSUE) && burst_last;
    assign done_o      = (state == ST_DONE) && !abort_i;

endmodule
`default_nettype wire
